// File: rtl/dbus_responder_if.sv
// Purpose: data-bus port between the core's M stage and the responder, plus the TX byte stream.
// Latency: bundle of wires only; reads are combinational, stores commit on the rising edge.
// Backpressure: tx_valid/tx_ready handshake on the byte stream; the core side never stalls.
interface dbus_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] addr;       // byte address (aluout)
    logic [WIDTH-1:0] writedata;  // store data
    logic             memwrite;   // store strobe
    logic [WIDTH-1:0] readdata;   // combinational load data
    logic [7:0]       tx_data;    // FIFO head byte, 0 when empty
    logic             tx_valid;   // FIFO non-empty
    logic             tx_ready;   // sink takes tx_data this cycle
    logic             irq;        // timer interrupt level

    modport master (
        output addr, writedata, memwrite, tx_ready,
        input  readdata, tx_data, tx_valid, irq
    );

    modport slave (
        input  addr, writedata, memwrite, tx_ready,
        output readdata, tx_data, tx_valid, irq
    );
endinterface

// File: rtl/dbus_responder.sv
// Purpose: word RAM plus MMIO window (TX FIFO, timer with compare/irq) behind the core's data port.
// Latency: combinational reads, writes commit at the rising edge; a pushed byte is on tx_data one cycle later.
// Backpressure: the FIFO pops on tx_valid & tx_ready; a push into a full FIFO with no pop is dropped and flagged.
// Ports: clk, rst (async, active-high), bus (dbus_if.slave: addr/writedata/memwrite/readdata,
//        tx_data/tx_valid/tx_ready, irq).
module dbus_responder #(
    parameter int WIDTH     = 32,
    parameter int DMEMDEPTH = 10,
    parameter int FIFODEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    dbus_if.slave  bus
);
    localparam int PW = $clog2(FIFODEPTH);
    localparam int LW = PW + 1;

    // Data RAM, intentionally never reset so contents survive a reset pulse.
    logic [WIDTH-1:0] mem_q [2**DMEMDEPTH];
    logic [7:0]       fifo_q [FIFODEPTH];

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d, exp_q, exp_d;
    logic [WIDTH-1:0] count_q, count_d, compare_q, compare_d;
    logic [1:0]       ctrl_q, ctrl_d;

    logic                 io_sel;
    logic [7:0]           off;
    logic [DMEMDEPTH-1:0] ram_idx;
    logic                 wr_io, wr_txdata, wr_status, wr_count, wr_compare, wr_ctrl;
    logic                 empty, full, pop, push_ok, match;
    logic [15:0]          status;
    logic [WIDTH-1:0]     rdata;
    logic                 unused_ok;

    assign io_sel  = (bus.addr[31:16] == 16'hFFFF);
    assign off     = bus.addr[7:0];
    assign ram_idx = bus.addr[DMEMDEPTH+1:2];
    // Address bits above the RAM index alias; fold them here so they count as read.
    assign unused_ok = &{1'b0, bus.addr};

    assign wr_io      = bus.memwrite & io_sel;
    assign wr_txdata  = wr_io & (off == 8'h00);
    assign wr_status  = wr_io & (off == 8'h04);
    assign wr_count   = wr_io & (off == 8'h08);
    assign wr_compare = wr_io & (off == 8'h0C);
    assign wr_ctrl    = wr_io & (off == 8'h10);

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(FIFODEPTH));
    assign pop     = ~empty & bus.tx_ready;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push_ok = wr_txdata & (~full | pop);
    // Match uses the pre-write COUNT, so a software COUNT write cannot cause an expire itself.
    assign match   = ctrl_q[0] & (count_q == compare_q);

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        exp_d     = exp_q;
        count_d   = count_q;
        compare_d = compare_q;
        ctrl_d    = ctrl_q;

        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (wr_status && bus.writedata[3]) ovf_d = 1'b0;
        if (wr_txdata && !push_ok)         ovf_d = 1'b1;

        // Hardware set is applied after the software clear so it wins a collision.
        if (wr_status && bus.writedata[2]) exp_d = 1'b0;
        if (match)                         exp_d = 1'b1;

        if (wr_count)       count_d = bus.writedata;
        else if (ctrl_q[0]) count_d = match ? '0 : count_q + WIDTH'(1);

        if (wr_compare) compare_d = bus.writedata;
        if (wr_ctrl)    ctrl_d    = bus.writedata[1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            exp_q     <= 1'b0;
            count_q   <= '0;
            compare_q <= '1;
            ctrl_q    <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            exp_q     <= exp_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // Storage arrays carry no reset; validity comes from level/pointers.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= bus.writedata[7:0];
        if (bus.memwrite && !io_sel) mem_q[ram_idx] <= bus.writedata;
    end

    assign status = {8'(level_q), 4'h0, ovf_q, exp_q, full, empty};

    always_comb begin
        rdata = '0;
        if (io_sel) begin
            case (off)
                8'h04:   rdata = WIDTH'(status);
                8'h08:   rdata = count_q;
                8'h0C:   rdata = compare_q;
                8'h10:   rdata = {{(WIDTH-2){1'b0}}, ctrl_q};
                default: rdata = '0;
            endcase
        end else begin
            rdata = mem_q[ram_idx];
        end
    end

    assign bus.readdata = rdata;
    // Gated by level so reset clears the visible byte without resetting the array.
    assign bus.tx_valid = ~empty;
    assign bus.tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign bus.irq      = exp_q & ctrl_q[1];
endmodule
